// File: rtl/fb_filler_pkg.sv
// Shared constants, state type and helpers for the framebuffer FIFO filler.
// Wishbone registered-feedback cycle types and the burst FSM states.
package fb_filler_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    function automatic int frame_words(input int hdisp, input int vdisp);
        return hdisp * vdisp;
    endfunction

endpackage

// File: rtl/fb_fifo_filler.sv
// Wishbone burst read master streaming a framebuffer into the pixel FIFO.
// Bursts start only when the FIFO has room for a whole burst.
module fb_fifo_filler
    import fb_filler_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          HDISP      = 800,
    parameter int          VDISP      = 480,
    parameter int          BURST_LEN  = 16,
    parameter int          DATA_WIDTH = 32
) (
    input  logic                  wclk,
    input  logic                  rst_n,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [31:0]           wb_adr,
    output logic [3:0]            wb_sel,
    output logic [2:0]            wb_cti,
    output logic [1:0]            wb_bte,
    input  logic                  wb_ack,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] fifo_wdata,
    output logic                  fifo_write,
    input  logic                  fifo_wfull,
    input  logic                  fifo_walmost_full,
    input  logic                  frame_sync,
    output logic                  frame_end
);

    localparam int FRAME_WORDS = frame_words(HDISP, VDISP);
    localparam int CNT_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_WORDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    state_t                  r_state;
    logic                    r_cyc;
    logic [31:0]             r_adr;
    logic [2:0]              r_cti;
    logic [CNT_W-1:0]        r_cnt;
    logic [BEAT_W-1:0]       r_beat;
    logic                    r_sync_pending;
    logic                    r_fifo_write;
    logic [DATA_WIDTH-1:0]   r_fifo_wdata;
    logic                    r_frame_end;

    logic [BEAT_W-1:0]       w_beat_nxt;

    assign w_beat_nxt = r_beat + BEAT_W'(1);

    always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_cyc          <= 1'b0;
            r_adr          <= BASE_ADDR;
            r_cti          <= CTI_CLASSIC;
            r_cnt          <= '0;
            r_beat         <= '0;
            r_sync_pending <= 1'b0;
            r_fifo_write   <= 1'b0;
            r_fifo_wdata   <= '0;
            r_frame_end    <= 1'b0;
        end else begin
            r_fifo_write <= r_cyc & wb_ack;
            r_fifo_wdata <= wb_dat_i;
            r_frame_end  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (r_sync_pending || frame_sync) begin
                        r_cnt          <= '0;
                        r_adr          <= BASE_ADDR;
                        r_sync_pending <= 1'b0;
                    end else if (!fifo_walmost_full) begin
                        r_state <= BURST;
                        r_cyc   <= 1'b1;
                        r_beat  <= '0;
                        r_cti   <= (LAST_BEAT == '0) ? CTI_EOB : CTI_INCR;
                    end
                end
                BURST: begin
                    // Restart is deferred so the current burst drains cleanly.
                    if (frame_sync) begin
                        r_sync_pending <= 1'b1;
                    end
                    if (wb_ack) begin
                        if (r_cnt == LAST_WORD) begin
                            r_cnt       <= '0;
                            r_adr       <= BASE_ADDR;
                            r_frame_end <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            r_adr <= r_adr + 32'd4;
                        end
                        if (r_beat == LAST_BEAT) begin
                            r_state <= IDLE;
                            r_cyc   <= 1'b0;
                            r_cti   <= CTI_CLASSIC;
                        end else begin
                            r_beat <= w_beat_nxt;
                            r_cti  <= (w_beat_nxt == LAST_BEAT) ? CTI_EOB
                                                                : CTI_INCR;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_cyc     = r_cyc;
    assign wb_stb     = r_cyc;
    assign wb_we      = 1'b0;
    assign wb_adr     = r_adr;
    assign wb_sel     = 4'hF;
    assign wb_cti     = r_cti;
    assign wb_bte     = BTE_LINEAR;
    assign fifo_write = r_fifo_write;
    assign fifo_wdata = r_fifo_wdata;
    assign frame_end  = r_frame_end;

    // FIFO threshold must leave room for a full burst in flight.
    a_no_overflow: assert property (
        @(posedge wclk) disable iff (!rst_n) !(fifo_write && fifo_wfull)
    );

endmodule

// File: tb/tb_fb_fifo_filler.sv
// Scoreboard bench for fb_fifo_filler with a small 4x8 frame.
// A slave process checks each beat against queued expectations.
module tb_fb_fifo_filler;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        wclk = 1'b0;
    logic        rst_n;
    logic        wb_cyc, wb_stb, wb_we;
    logic [31:0] wb_adr;
    logic [3:0]  wb_sel;
    logic [2:0]  wb_cti;
    logic [1:0]  wb_bte;
    logic        wb_ack;
    logic [31:0] wb_dat_i;
    logic [31:0] fifo_wdata;
    logic        fifo_write;
    logic        fifo_wfull;
    logic        fifo_walmost_full;
    logic        frame_sync;
    logic        frame_end;

    always #5 wclk = ~wclk;

    fb_fifo_filler #(
        .BASE_ADDR (BASE),
        .HDISP     (4),
        .VDISP     (8),
        .BURST_LEN (16),
        .DATA_WIDTH(32)
    ) dut (
        .wclk             (wclk),
        .rst_n            (rst_n),
        .wb_cyc           (wb_cyc),
        .wb_stb           (wb_stb),
        .wb_we            (wb_we),
        .wb_adr           (wb_adr),
        .wb_sel           (wb_sel),
        .wb_cti           (wb_cti),
        .wb_bte           (wb_bte),
        .wb_ack           (wb_ack),
        .wb_dat_i         (wb_dat_i),
        .fifo_wdata       (fifo_wdata),
        .fifo_write       (fifo_write),
        .fifo_wfull       (fifo_wfull),
        .fifo_walmost_full(fifo_walmost_full),
        .frame_sync       (frame_sync),
        .frame_end        (frame_end)
    );

    typedef struct {
        logic [31:0] adr;
        logic [2:0]  cti;
        bit          eof;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] dq[$];
    int n_pass  = 0;
    int n_total = 0;
    int wait_n    = 0;
    int sync_beat = -1;
    int bi   = 0;
    int wcnt = 0;
    int seq  = 0;
    bit cur_eof = 1'b0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    task automatic push_burst(input logic [31:0] a, input bit eof);
        beat_t e;
        for (int i = 0; i < 16; i++) begin
            e.adr = a + 32'(4 * i);
            e.cti = (i == 15) ? 3'b111 : 3'b010;
            e.eof = eof && (i == 15);
            exp_q.push_back(e);
        end
    endtask

    task automatic run_burst(input int exp_cycles);
        int n;
        fifo_walmost_full = 1'b0;
        @(negedge wclk);
        chk(wb_cyc == 1'b1, "burst_start", 32'(wb_cyc), 32'd1);
        fifo_walmost_full = 1'b1;
        n = 1;
        while (n < 200) begin
            @(negedge wclk);
            if (!wb_cyc) break;
            n++;
        end
        chk(n == exp_cycles, "burst_cycles", 32'(n), 32'(exp_cycles));
    endtask

    task automatic idle_check(input int cycles, input logic [31:0] adr);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge wclk);
            if (wb_cyc || fifo_write) ok = 1'b0;
        end
        chk(ok, "idle_quiet", 32'(wb_cyc), 32'd0);
        chk(wb_adr == adr, "idle_adr", wb_adr, adr);
    endtask

    // Slave and output monitor.
    initial begin
        beat_t       e;
        logic [31:0] d;
        bit          fe_exp;
        forever begin
            @(negedge wclk);
            if (!rst_n) begin
                wb_ack = 1'b0;
                frame_sync = 1'b0;
                bi = 0;
                wcnt = 0;
            end else begin
                fe_exp = wb_ack && cur_eof;
                if (fifo_write || wb_ack) begin
                    chk(fifo_write == wb_ack, "push_timing",
                        32'(fifo_write), 32'(wb_ack));
                    if (fifo_write && dq.size() > 0) begin
                        d = dq.pop_front();
                        chk(fifo_wdata == d, "push_data", fifo_wdata, d);
                    end
                end
                if (frame_end || fe_exp)
                    chk(frame_end == fe_exp, "frame_end",
                        32'(frame_end), 32'(fe_exp));
                wb_ack = 1'b0;
                frame_sync = 1'b0;
                if (wb_cyc && wb_stb) begin
                    if (wcnt >= wait_n) begin
                        if (exp_q.size() == 0) begin
                            chk(1'b0, "unexpected_beat", wb_adr, 32'd0);
                            cur_eof = 1'b0;
                        end else begin
                            e = exp_q.pop_front();
                            chk(wb_adr == e.adr, "beat_adr", wb_adr, e.adr);
                            chk(wb_cti == e.cti, "beat_cti",
                                32'(wb_cti), 32'(e.cti));
                            cur_eof = e.eof;
                        end
                        seq++;
                        d = {16'hBEEF ^ seq[15:0], wb_adr[15:0]};
                        wb_dat_i = d;
                        dq.push_back(d);
                        wb_ack = 1'b1;
                        if (bi == sync_beat) frame_sync = 1'b1;
                        bi++;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end else begin
                    bi = 0;
                    wcnt = 0;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        wb_ack = 1'b0;
        wb_dat_i = 32'd0;
        fifo_wfull = 1'b0;
        fifo_walmost_full = 1'b1;
        frame_sync = 1'b0;
        repeat (5) @(negedge wclk);
        chk(!wb_cyc && !wb_stb, "rst_cyc", 32'(wb_cyc), 32'd0);
        chk(wb_adr == BASE, "rst_adr", wb_adr, BASE);
        chk(wb_cti == 3'b000, "rst_cti", 32'(wb_cti), 32'd0);
        chk(!fifo_write && fifo_wdata == 32'd0, "rst_fifo",
            fifo_wdata, 32'd0);
        chk(!frame_end, "rst_frame_end", 32'(frame_end), 32'd0);
        chk(!wb_we && wb_sel == 4'hF && wb_bte == 2'b00, "const_outs",
            {27'd0, wb_we, wb_sel}, 32'h0000_000F);
        rst_n = 1'b1;
        idle_check(8, BASE);

        push_burst(BASE, 1'b0);
        run_burst(16);
        idle_check(4, BASE + 32'h40);

        wait_n = 2;
        push_burst(BASE + 32'h40, 1'b1);
        run_burst(48);
        wait_n = 0;
        idle_check(4, BASE);

        sync_beat = 5;
        push_burst(BASE, 1'b0);
        run_burst(16);
        sync_beat = -1;
        idle_check(4, BASE);

        push_burst(BASE, 1'b0);
        run_burst(16);
        idle_check(4, BASE + 32'h40);

        sync_beat = 15;
        push_burst(BASE + 32'h40, 1'b1);
        run_burst(16);
        sync_beat = -1;
        idle_check(4, BASE);

        push_burst(BASE, 1'b0);
        run_burst(16);
        idle_check(10, BASE + 32'h40);

        chk(exp_q.size() == 0, "beats_left", 32'(exp_q.size()), 32'd0);
        chk(dq.size() == 0, "pushes_left", 32'(dq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fb_fifo_filler.md
Name: fb_fifo_filler

Overview:
Wishbone read master that streams a framebuffer from memory into the write port of the video pixel async FIFO. It issues fixed-length incrementing read bursts whenever the FIFO is not almost full. Each acknowledged word is pushed into the FIFO, and the read address wraps at the end of each frame. It runs entirely in the FIFO write-clock domain; the video timing side drains the FIFO in the pixel domain.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0)
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
BURST_LEN, 16, words per Wishbone burst; HDISP*VDISP must be a multiple of BURST_LEN
DATA_WIDTH, 32, pixel word width (one pixel per word)

Ports:
wclk  in  1  system/FIFO write clock
rst_n  in  1  asynchronous reset, active low
wb_cyc  out  1  Wishbone cycle
wb_stb  out  1  Wishbone strobe
wb_we  out  1  always 0
wb_adr  out  32  byte address, steps by 4
wb_sel  out  4  always 4'hF
wb_cti  out  3  3'b010 during a burst, 3'b111 on the last beat
wb_bte  out  2  always 2'b00 (linear)
wb_ack  in  1  slave acknowledge
wb_dat_i  in  DATA_WIDTH  read data
fifo_wdata  out  DATA_WIDTH  to async FIFO wdata
fifo_write  out  1  to async FIFO write
fifo_wfull  in  1  from async FIFO wfull
fifo_walmost_full  in  1  from async FIFO walmost_full
frame_sync  in  1  single-cycle pulse: restart the frame at BASE_ADDR
frame_end  out  1  single-cycle pulse when the last word of a frame is acknowledged

Behaviour:
- Clock and reset: one clock, wclk. Reset rst_n is asynchronous and active low.
- Reset values: wb_cyc=0, wb_stb=0, wb_cti=0, wb_adr=BASE_ADDR, fifo_write=0, fifo_wdata=0, frame_end=0, state=IDLE, word counter=0, beat counter=0, sync_pending=0.
- Derived constant: FRAME_WORDS = HDISP*VDISP. The word counter width is $clog2(FRAME_WORDS).
- State IDLE:
  - If sync_pending or frame_sync is set: clear the word counter, set wb_adr=BASE_ADDR, clear sync_pending, stay in IDLE for this cycle.
  - Else if fifo_walmost_full=0: go to BURST next cycle with wb_cyc=wb_stb=1 and the beat counter cleared.
- State BURST: wb_cyc and wb_stb are held high. On each wb_ack:
  - wb_adr += 4 and the word counter increments.
  - If the word counter was FRAME_WORDS-1: word counter and wb_adr wrap to 0 and BASE_ADDR, and frame_end pulses on the next cycle.
  - On the BURST_LEN-th ack: wb_cyc=wb_stb=0 next cycle, return to IDLE (at least one idle cycle between bursts).
- wb_cti is 3'b111 exactly while the beat counter equals BURST_LEN-1, otherwise 3'b010.
- Wait states: with wb_ack=0, all outputs hold; there is no timeout.
- FIFO push: fifo_write <= wb_cyc & wb_ack and fifo_wdata <= wb_dat_i (registered, 1-cycle latency from ack).
- fifo_walmost_full is sampled only in IDLE. A started burst always completes.
- Integration rule: the FIFO ALMOST_FULL_THRESHOLD must be <= DEPTH-BURST_LEN-2, so fifo_wfull is never high when fifo_write=1. A simulation assertion flags fifo_write & fifo_wfull.
- frame_sync during BURST: set sync_pending. The burst completes at its current addresses; the restart is applied in IDLE. A frame_sync arriving in the same cycle as the final ack is also latched.
- Frame wrap and frame_sync in the same cycle: the result is address BASE_ADDR either way, with a single frame_end pulse.
- Reset asserted mid-burst: wb_cyc/wb_stb drop immediately (asynchronously); partial burst data is discarded. The FIFO is reset by the same system reset.

Decomposition:
- Package fb_filler_pkg holds:
  - CTI_INCR = 3'b010
  - CTI_EOB = 3'b111
  - BTE_LINEAR = 2'b00
  - state enum {IDLE, BURST}
  - function frame_words(HDISP, VDISP)
- No sub-module: the address/word counter and the FSM are inline (around 150 lines of RTL).

Test Plan:
1. Reset held 5 cycles, then released with fifo_walmost_full=1 -> wb_cyc=0, wb_adr=BASE_ADDR, fifo_write=0 throughout.
2. fifo_walmost_full=0, slave acks every cycle, BURST_LEN=16 -> 16 beats at addresses 0x00..0x3C; wb_cti=010 on beats 0-14 and 111 on beat 15; 16 fifo_write pulses, each 1 cycle after its ack, data matching.
3. Slave inserts 2 wait states per beat -> burst takes 48 cycles, address/data still correct, no extra or missing fifo_write.
4. HDISP=4, VDISP=8, BURST_LEN=16 -> after 32 acks wb_adr returns to BASE_ADDR; frame_end pulses once, 1 cycle after ack 32.
5. frame_sync pulsed on beat 5 of the second burst -> that burst finishes at 0x7C, and the next burst starts at BASE_ADDR.
6. fifo_walmost_full raised mid-burst -> burst completes all 16 beats, then no new wb_cyc until it is deasserted; the next burst starts 1 cycle later.
